// File: rtl/tag_ram_assoc_pkg.sv
// Shared definitions for the set-associative tag store.
//   flush_state_e : flush sequencer states
//   way_bits()    : width of a way number (at least one bit, even for WAYS=1)
package tag_ram_assoc_pkg;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_FLUSH = 1'b1
   } flush_state_e;

   function automatic int way_bits(input int ways);
      return (ways > 1) ? $clog2(ways) : 1;
   endfunction

endpackage

// File: rtl/tag_ram_assoc_way.sv
// One way of the tag store: per-set tag and valid bit with two compare ports.
//   clk, reset            : clock, synchronous active-high reset (clears valid bits only)
//   lk_index_i/lk_tag_i   : lookup set and tag; lk_valid_o/lk_match_o/lk_tag_o report that set
//   in_index_i/in_tag_i   : install set and tag; in_valid_o/in_match_o report that set
//   wr_en_i               : write in_tag_i into set in_index_i and mark it valid
//   clr_en_i/clr_index_i  : invalidate one set (flush walk)
module tag_ram_assoc_way
   import tag_ram_assoc_pkg::*;
#(
   parameter int INDEX   = 3,
   parameter int TAGBITS = 5
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [INDEX-1:0]   lk_index_i,
   input  logic [TAGBITS-1:0] lk_tag_i,
   output logic               lk_valid_o,
   output logic               lk_match_o,
   output logic [TAGBITS-1:0] lk_tag_o,
   input  logic [INDEX-1:0]   in_index_i,
   input  logic [TAGBITS-1:0] in_tag_i,
   output logic               in_valid_o,
   output logic               in_match_o,
   input  logic               wr_en_i,
   input  logic               clr_en_i,
   input  logic [INDEX-1:0]   clr_index_i
);

   localparam int SETS = 1 << INDEX;

   logic [TAGBITS-1:0] tag_q [SETS];
   logic [SETS-1:0]    valid_q;

   // Tag storage is never reset; a line is only meaningful while its valid bit is set.
   always_ff @(posedge clk) begin
      if (wr_en_i) begin
         tag_q[in_index_i] <= in_tag_i;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         valid_q <= '0;
      end else begin
         if (clr_en_i) begin
            valid_q[clr_index_i] <= 1'b0;
         end
         if (wr_en_i) begin
            valid_q[in_index_i] <= 1'b1;
         end
      end
   end

   assign lk_valid_o = valid_q[lk_index_i];
   assign lk_tag_o   = tag_q[lk_index_i];
   assign lk_match_o = lk_valid_o && (lk_tag_o == lk_tag_i);

   assign in_valid_o = valid_q[in_index_i];
   assign in_match_o = in_valid_o && (tag_q[in_index_i] == in_tag_i);

endmodule

// File: rtl/tag_ram_assoc.sv
// Set-associative tag store with registered hit compare, invalid-first/round-robin
// victim selection, optional autofill of read misses and a sequenced full flush.
//   clk, reset                 : clock, synchronous active-high reset
//   address                    : lookup address (index = low INDEX bits, tag = rest)
//   read_signal, write_signal  : lookup requests (only reads autofill)
//   fill_signal, fill_address  : explicit install of fill_address's tag
//   flush_signal               : start invalidating every set
//   valid_out, hit, hit_way    : registered lookup result (1-cycle valid pulse)
//   victim_way, Tagout         : way a fill would use; hit tag or victim's tag
//   busy                       : flush in progress
//
// state    | meaning
// ST_IDLE  | lookups and installs accepted
// ST_FLUSH | clearing set cnt_q each cycle; lookups and installs ignored
module tag_ram_assoc
   import tag_ram_assoc_pkg::*;
#(
   parameter int INDEX      = 3,
   parameter int MEMORYBITS = 8,
   parameter int WAYS       = 2,
   parameter int AUTOFILL   = 1,
   localparam int TAGBITS   = MEMORYBITS - INDEX,
   localparam int WAYBITS   = way_bits(WAYS)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [MEMORYBITS-1:0] address,
   input  logic                  read_signal,
   input  logic                  write_signal,
   input  logic                  fill_signal,
   input  logic [MEMORYBITS-1:0] fill_address,
   input  logic                  flush_signal,
   output logic                  valid_out,
   output logic                  hit,
   output logic [WAYBITS-1:0]    hit_way,
   output logic [WAYBITS-1:0]    victim_way,
   output logic [TAGBITS-1:0]    Tagout,
   output logic                  busy
);

   localparam int SETS = 1 << INDEX;

   flush_state_e              state_q, state_d;
   logic [INDEX-1:0]          cnt_q, cnt_d;
   logic [WAYBITS-1:0]        ptr_q [SETS];
   logic                      af_pend_q;
   logic [MEMORYBITS-1:0]     af_addr_q;
   logic                      valid_out_q, hit_q;
   logic [WAYBITS-1:0]        hit_way_q, victim_q;
   logic [TAGBITS-1:0]        tag_out_q;

   logic [INDEX-1:0]          lk_index, in_index;
   logic [TAGBITS-1:0]        lk_tag, in_tag;
   logic [MEMORYBITS-1:0]     in_addr;
   logic [WAYS-1:0]           lk_valid, lk_match, in_valid, in_match, wr_en;
   logic [TAGBITS-1:0]        lk_tags [WAYS];
   logic                      busy_w, flush_go, lk_acc, ins_en;
   logic                      lk_hit, in_hit;
   logic [WAYBITS-1:0]        lk_hit_way, lk_victim, in_hit_way, in_victim, wr_sel, ptr_next;
   logic [TAGBITS-1:0]        lk_tag_out;

   assign busy_w   = (state_q == ST_FLUSH);
   assign flush_go = (state_q == ST_IDLE) && flush_signal;
   assign lk_acc   = (read_signal || write_signal) && !busy_w;

   // Explicit fill wins over a pending autofill; neither happens while flushing
   // or on the edge that starts a flush.
   assign ins_en  = (fill_signal || af_pend_q) && !busy_w && !flush_go;
   assign in_addr = fill_signal ? fill_address : af_addr_q;

   assign lk_index = address[INDEX-1:0];
   assign lk_tag   = address[MEMORYBITS-1:INDEX];
   assign in_index = in_addr[INDEX-1:0];
   assign in_tag   = in_addr[MEMORYBITS-1:INDEX];

   for (genvar w = 0; w < WAYS; w++) begin : g_way
      tag_ram_assoc_way #(
         .INDEX   (INDEX),
         .TAGBITS (TAGBITS)
      ) u_way (
         .clk         (clk),
         .reset       (reset),
         .lk_index_i  (lk_index),
         .lk_tag_i    (lk_tag),
         .lk_valid_o  (lk_valid[w]),
         .lk_match_o  (lk_match[w]),
         .lk_tag_o    (lk_tags[w]),
         .in_index_i  (in_index),
         .in_tag_i    (in_tag),
         .in_valid_o  (in_valid[w]),
         .in_match_o  (in_match[w]),
         .wr_en_i     (wr_en[w]),
         .clr_en_i    (busy_w),
         .clr_index_i (cnt_q)
      );
   end

   // Descending scan so the lowest-numbered matching / invalid way wins.
   always_comb begin
      lk_hit     = 1'b0;
      lk_hit_way = '0;
      lk_victim  = ptr_q[lk_index];
      in_hit     = 1'b0;
      in_hit_way = '0;
      in_victim  = ptr_q[in_index];
      for (int w = WAYS - 1; w >= 0; w--) begin
         if (lk_match[w]) begin
            lk_hit     = 1'b1;
            lk_hit_way = WAYBITS'(w);
         end
         if (!lk_valid[w]) begin
            lk_victim = WAYBITS'(w);
         end
         if (in_match[w]) begin
            in_hit     = 1'b1;
            in_hit_way = WAYBITS'(w);
         end
         if (!in_valid[w]) begin
            in_victim = WAYBITS'(w);
         end
      end
   end

   // A tag already present is rewritten in place so a set never holds duplicates.
   assign wr_sel   = in_hit ? in_hit_way : in_victim;
   assign ptr_next = (WAYS == 1) ? '0 : in_victim + 1'b1;

   always_comb begin
      wr_en      = '0;
      lk_tag_out = '0;
      for (int w = 0; w < WAYS; w++) begin
         if (ins_en && (wr_sel == WAYBITS'(w))) begin
            wr_en[w] = 1'b1;
         end
         if ((lk_hit ? lk_hit_way : lk_victim) == WAYBITS'(w)) begin
            lk_tag_out = lk_tags[w];
         end
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         ST_IDLE: begin
            if (flush_signal) begin
               state_d = ST_FLUSH;
               cnt_d   = '0;
            end
         end
         ST_FLUSH: begin
            cnt_d = cnt_q + 1'b1;
            if (&cnt_q) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         af_pend_q   <= 1'b0;
         af_addr_q   <= '0;
         valid_out_q <= 1'b0;
         hit_q       <= 1'b0;
         hit_way_q   <= '0;
         victim_q    <= '0;
         tag_out_q   <= '0;
         for (int s = 0; s < SETS; s++) begin
            ptr_q[s] <= '0;
         end
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         valid_out_q <= lk_acc;
         af_pend_q   <= (AUTOFILL != 0) && lk_acc && read_signal && !lk_hit;
         if (lk_acc) begin
            af_addr_q <= address;
            hit_q     <= lk_hit;
            hit_way_q <= lk_hit_way;
            victim_q  <= lk_victim;
            tag_out_q <= lk_tag_out;
         end
         if (busy_w) begin
            ptr_q[cnt_q] <= '0;
         end else if (ins_en && !in_hit) begin
            ptr_q[in_index] <= ptr_next;
         end
      end
   end

   assign valid_out  = valid_out_q;
   assign hit        = hit_q;
   assign hit_way    = hit_way_q;
   assign victim_way = victim_q;
   assign Tagout     = tag_out_q;
   assign busy       = busy_w;

endmodule

// File: tb/tb_tag_ram_assoc.sv
module tb_tag_ram_assoc;

   localparam int INDEX      = 3;
   localparam int MEMORYBITS = 8;
   localparam int WAYS       = 2;
   localparam int AUTOFILL   = 1;
   localparam logic H = 1'b1;
   localparam logic L = 1'b0;

   logic       clk = 1'b0;
   logic       reset, read_signal, write_signal, fill_signal, flush_signal;
   logic [7:0] address, fill_address;
   logic       valid_out, hit, busy;
   logic [0:0] hit_way, victim_way;
   logic [4:0] Tagout;

   int checks   = 0;
   int failures = 0;

   tag_ram_assoc #(
      .INDEX      (INDEX),
      .MEMORYBITS (MEMORYBITS),
      .WAYS       (WAYS),
      .AUTOFILL   (AUTOFILL)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .address      (address),
      .read_signal  (read_signal),
      .write_signal (write_signal),
      .fill_signal  (fill_signal),
      .fill_address (fill_address),
      .flush_signal (flush_signal),
      .valid_out    (valid_out),
      .hit          (hit),
      .hit_way      (hit_way),
      .victim_way   (victim_way),
      .Tagout       (Tagout),
      .busy         (busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       rst, rd, wr, fl;
      logic [7:0] addr, faddr;
      logic       ck_res, ck_tag;
      logic       e_valid, e_hit;
      logic [0:0] e_hw, e_vic;
      logic [4:0] e_tag;
   } vec_t;

   localparam int NV = 25;
   vec_t vecs [NV];

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic drive(input logic rst, input logic rd, input logic wr, input logic fl,
                        input logic fsh, input logic [7:0] a, input logic [7:0] fa);
      reset        = rst;
      read_signal  = rd;
      write_signal = wr;
      fill_signal  = fl;
      flush_signal = fsh;
      address      = a;
      fill_address = fa;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      logic [7:0] fa [4];

      //           rst rd wr fl  addr   faddr  ckr ckt val hit hw  vic tag
      vecs[0]  = '{H, L, L, L, 8'h00, 8'h00, H, H, L, L, L, L, 5'h00};
      vecs[1]  = '{L, H, L, L, 8'h2B, 8'h00, H, L, H, L, L, L, 5'h00};
      vecs[2]  = '{L, L, L, L, 8'h00, 8'h00, H, L, L, L, L, L, 5'h00};
      vecs[3]  = '{L, H, L, L, 8'h2B, 8'h00, H, H, H, H, L, H, 5'h05};
      vecs[4]  = '{H, L, L, L, 8'h00, 8'h00, H, H, L, L, L, L, 5'h00};
      vecs[5]  = '{L, L, L, H, 8'h00, 8'h0B, L, L, L, L, L, L, 5'h00};
      vecs[6]  = '{L, L, L, H, 8'h00, 8'h0B, L, L, L, L, L, L, 5'h00};
      vecs[7]  = '{L, L, L, H, 8'h00, 8'h13, L, L, L, L, L, L, 5'h00};
      vecs[8]  = '{L, H, L, L, 8'h0B, 8'h00, H, H, H, H, L, L, 5'h01};
      vecs[9]  = '{L, H, L, L, 8'h13, 8'h00, H, H, H, H, H, L, 5'h02};
      vecs[10] = '{H, L, L, L, 8'h00, 8'h00, H, H, L, L, L, L, 5'h00};
      vecs[11] = '{L, L, L, H, 8'h00, 8'h0B, L, L, L, L, L, L, 5'h00};
      vecs[12] = '{L, L, L, H, 8'h00, 8'h13, L, L, L, L, L, L, 5'h00};
      vecs[13] = '{L, L, L, H, 8'h00, 8'h1B, L, L, L, L, L, L, 5'h00};
      vecs[14] = '{L, H, L, L, 8'h0B, 8'h00, H, H, H, L, L, H, 5'h02};
      vecs[15] = '{L, H, L, L, 8'h13, 8'h00, H, H, H, H, H, H, 5'h02};
      vecs[16] = '{L, H, L, L, 8'h1B, 8'h00, H, H, H, H, L, L, 5'h03};
      vecs[17] = '{L, H, L, L, 8'h0B, 8'h00, H, H, H, H, H, L, 5'h01};
      vecs[18] = '{H, L, L, L, 8'h00, 8'h00, H, H, L, L, L, L, 5'h00};
      vecs[19] = '{L, H, L, H, 8'h2B, 8'h2B, H, L, H, L, L, L, 5'h00};
      vecs[20] = '{L, H, L, L, 8'h2B, 8'h00, H, H, H, H, L, H, 5'h05};
      vecs[21] = '{L, L, L, L, 8'h00, 8'h00, H, H, L, H, L, H, 5'h05};
      vecs[22] = '{L, L, H, L, 8'h33, 8'h00, H, L, H, L, L, H, 5'h00};
      vecs[23] = '{L, L, L, L, 8'h00, 8'h00, L, L, L, L, L, L, 5'h00};
      vecs[24] = '{L, H, L, L, 8'h33, 8'h00, H, L, H, L, L, H, 5'h00};

      drive(L, L, L, L, L, 8'h00, 8'h00);

      for (int i = 0; i < NV; i++) begin
         drive(vecs[i].rst, vecs[i].rd, vecs[i].wr, vecs[i].fl, L, vecs[i].addr, vecs[i].faddr);
         tick();
         chk($sformatf("v%0d valid_out", i), 8'(valid_out), 8'(vecs[i].e_valid));
         chk($sformatf("v%0d busy", i), 8'(busy), 8'h00);
         if (vecs[i].ck_res) begin
            chk($sformatf("v%0d hit", i), 8'(hit), 8'(vecs[i].e_hit));
            chk($sformatf("v%0d hit_way", i), 8'(hit_way), 8'(vecs[i].e_hw));
            chk($sformatf("v%0d victim_way", i), 8'(victim_way), 8'(vecs[i].e_vic));
         end
         if (vecs[i].ck_tag) begin
            chk($sformatf("v%0d Tagout", i), 8'(Tagout), 8'(vecs[i].e_tag));
         end
      end

      // Full flush: populate sets 0 and 7, then walk all sets.
      fa[0] = 8'h00; fa[1] = 8'h07; fa[2] = 8'hF8; fa[3] = 8'hFF;
      drive(H, L, L, L, L, 8'h00, 8'h00);
      tick();
      for (int i = 0; i < 4; i++) begin
         drive(L, L, L, H, L, 8'h00, fa[i]);
         tick();
      end
      drive(L, H, L, L, L, 8'hFF, 8'h00);
      tick();
      chk("pre-flush hit", 8'(hit), 8'h01);
      chk("pre-flush hit_way", 8'(hit_way), 8'h01);
      chk("pre-flush Tagout", 8'(Tagout), 8'h1F);
      drive(L, L, L, L, H, 8'h00, 8'h00);
      tick();
      chk("flush busy start", 8'(busy), 8'h01);
      n = busy ? 1 : 0;
      // Reads, fills and a second flush request are all driven while busy and must be ignored.
      drive(L, H, L, H, L, 8'h07, 8'h00);
      for (int k = 0; k < 20 && busy; k++) begin
         flush_signal = (k == 3);
         tick();
         chk($sformatf("flush k%0d valid_out", k), 8'(valid_out), 8'h00);
         if (busy) n++;
      end
      chk("flush busy cycles", 8'(n), 8'd8);
      drive(L, L, L, L, L, 8'h00, 8'h00);
      for (int i = 0; i < 4; i++) begin
         drive(L, L, H, L, L, fa[i], 8'h00);
         tick();
         chk($sformatf("post-flush %0h valid_out", fa[i]), 8'(valid_out), 8'h01);
         chk($sformatf("post-flush %0h hit", fa[i]), 8'(hit), 8'h00);
         chk($sformatf("post-flush %0h victim_way", fa[i]), 8'(victim_way), 8'h00);
      end

      // Reset at flush cycle 3 aborts the walk and clears everything.
      drive(H, L, L, L, L, 8'h00, 8'h00);
      tick();
      drive(L, L, L, H, L, 8'h00, 8'h07);
      tick();
      drive(L, L, L, H, L, 8'h00, 8'h03);
      tick();
      drive(L, H, L, L, L, 8'h07, 8'h00);
      tick();
      chk("pre-abort hit", 8'(hit), 8'h01);
      drive(L, L, L, L, H, 8'h00, 8'h00);
      tick();
      drive(L, L, L, L, L, 8'h00, 8'h00);
      tick();
      tick();
      chk("abort busy before reset", 8'(busy), 8'h01);
      drive(H, L, L, L, L, 8'h00, 8'h00);
      tick();
      chk("abort busy", 8'(busy), 8'h00);
      chk("abort valid_out", 8'(valid_out), 8'h00);
      chk("abort hit", 8'(hit), 8'h00);
      drive(L, L, L, L, L, 8'h00, 8'h00);
      tick();
      chk("abort busy stays low", 8'(busy), 8'h00);
      drive(L, L, H, L, L, 8'h07, 8'h00);
      tick();
      chk("abort 07 valid_out", 8'(valid_out), 8'h01);
      chk("abort 07 hit", 8'(hit), 8'h00);
      chk("abort 07 victim_way", 8'(victim_way), 8'h00);
      drive(L, L, H, L, L, 8'h03, 8'h00);
      tick();
      chk("abort 03 hit", 8'(hit), 8'h00);
      chk("abort 03 victim_way", 8'(victim_way), 8'h00);
      drive(L, L, L, L, L, 8'h00, 8'h00);
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
